// File: rtl/parking_pkg.sv
// Shared types and constants for the multi-bay parking meter.
//   bay_state_t : per-bay lifecycle state
//   COIN_*_VAL  : seconds credited per coin type
//   TIME_W      : width of a bay's remaining-time register (holds 0..99)
package parking_pkg;

   localparam int unsigned TIME_W = 7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_RUNNING,
      ST_EXPIRED
   } bay_state_t;

   localparam logic [TIME_W-1:0] COIN_A_VAL = TIME_W'(5);
   localparam logic [TIME_W-1:0] COIN_B_VAL = TIME_W'(10);
   localparam logic [TIME_W-1:0] COIN_C_VAL = TIME_W'(25);

endpackage

// File: rtl/meter_bay.sv
// One parking bay: remaining time plus IDLE/ARMED/RUNNING/EXPIRED lifecycle.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   credit, credit_en     : seconds to add this cycle, valid when credit_en=1
//   start_en, start       : bay is selected / level of the start switch
//   tick                  : one-cycle one-second strobe
//   time_left             : registered remaining seconds
//   running, expired      : registered state flags
module meter_bay
   import parking_pkg::*;
#(
   parameter int unsigned MAX_TIME = 99
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [TIME_W-1:0] credit,
   input  logic              credit_en,
   input  logic              start_en,
   input  logic              start,
   input  logic              tick,
   output logic [TIME_W-1:0] time_left,
   output logic              running,
   output logic              expired
);

   localparam int unsigned          SUM_W   = TIME_W + 1;
   localparam logic [SUM_W-1:0]     MAX_SUM = SUM_W'(MAX_TIME);

   bay_state_t        state;
   bay_state_t        state_nxt;
   logic [TIME_W-1:0] time_nxt;
   logic              running_nxt;
   logic              expired_nxt;
   logic              has_credit;
   logic [SUM_W-1:0]  add;
   logic [SUM_W-1:0]  add_dec;

   function automatic logic [TIME_W-1:0] sat(input logic [SUM_W-1:0] x);
      return (x > MAX_SUM) ? MAX_SUM[TIME_W-1:0] : x[TIME_W-1:0];
   endfunction

   // Sum is one bit wider so saturation sees the true overflow, never a wrap
   always_comb begin
      has_credit = credit_en && (credit != '0);
      add        = {1'b0, time_left} + (has_credit ? {1'b0, credit} : '0);
      add_dec    = tick ? (add - SUM_W'(1)) : add;
   end

   // State register (also holds time and registered flags)
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         time_left <= '0;
         running   <= 1'b0;
         expired   <= 1'b0;
      end else begin
         state     <= state_nxt;
         time_left <= time_nxt;
         running   <= running_nxt;
         expired   <= expired_nxt;
      end
   end

   // Next state and next time
   always_comb begin
      state_nxt = state;
      time_nxt  = time_left;
      case (state)
         ST_IDLE: begin
            if (has_credit) begin
               state_nxt = ST_ARMED;
               time_nxt  = sat({1'b0, credit});
            end
         end
         ST_ARMED: begin
            time_nxt = sat(add);
            if (start_en && start) state_nxt = ST_RUNNING;
         end
         ST_RUNNING: begin
            // Credit landing on the last tick keeps the bay alive
            time_nxt = sat(add_dec);
            if (add_dec == '0)               state_nxt = ST_EXPIRED;
            else if (start_en && !start)     state_nxt = ST_ARMED;
         end
         ST_EXPIRED: begin
            // Fresh credit restarts from zero, no decrement this cycle
            if (has_credit) begin
               time_nxt  = sat({1'b0, credit});
               state_nxt = (start_en && start) ? ST_RUNNING : ST_ARMED;
            end else begin
               time_nxt  = '0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            time_nxt  = '0;
         end
      endcase
   end

   // Flag values that accompany the next state
   always_comb begin
      running_nxt = (state_nxt == ST_RUNNING);
      expired_nxt = (state_nxt == ST_EXPIRED);
   end

endmodule

// File: rtl/parking_meter_multi.sv
// Multi-bay parking meter: coin edge detect, one-second divider, per-bay
// meters and BCD display of the selected bay.
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   sw_coin[2:0]        : debounced coin switches (A=5s, B=10s, C=25s)
//   sw_start            : run/pause level for the selected bay
//   bay_sel             : bay receiving coins/start and shown on display
//   time_tens/time_ones : registered BCD digits of the selected bay's time
//   expired, running    : registered per-bay flags
module parking_meter_multi
   import parking_pkg::*;
#(
   parameter int unsigned N_BAYS   = 4,
   parameter int unsigned MAX_TIME = 99,
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic [2:0]                                    sw_coin,
   input  logic                                          sw_start,
   input  logic [((N_BAYS > 1) ? $clog2(N_BAYS) : 1)-1:0] bay_sel,
   output logic [3:0]                                    time_tens,
   output logic [3:0]                                    time_ones,
   output logic [N_BAYS-1:0]                             expired,
   output logic [N_BAYS-1:0]                             running
);

   localparam int unsigned SEL_W = (N_BAYS > 1) ? $clog2(N_BAYS) : 1;
   localparam int unsigned DIV_W = $clog2(TICK_DIV);

   logic [2:0]        coin_q;
   logic [2:0]        rise;
   logic [TIME_W-1:0] credit;
   logic              credit_any;
   logic [DIV_W-1:0]  div_cnt;
   logic              tick;
   logic [TIME_W-1:0] bay_time [N_BAYS];
   logic [TIME_W-1:0] sel_time;

   // Coin edge register; reset loads current switches so held coins never credit
   always_ff @(posedge clk) begin
      coin_q <= sw_coin;
   end

   // All coins rising together merge into one credit
   always_comb begin
      rise       = sw_coin & ~coin_q;
      credit     = (rise[0] ? COIN_A_VAL : '0)
                 + (rise[1] ? COIN_B_VAL : '0)
                 + (rise[2] ? COIN_C_VAL : '0);
      credit_any = (rise != 3'b000);
      tick       = (div_cnt == DIV_W'(TICK_DIV - 1));
   end

   // Free-running one-second divider
   always_ff @(posedge clk) begin
      if (!reset)    div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + DIV_W'(1);
   end

   for (genvar i = 0; i < N_BAYS; i++) begin : g_bay
      logic hit;
      assign hit = (bay_sel == SEL_W'(i));

      meter_bay #(
         .MAX_TIME (MAX_TIME)
      ) u_bay (
         .clk       (clk),
         .reset     (reset),
         .credit    (credit),
         .credit_en (credit_any && hit),
         .start_en  (hit),
         .start     (sw_start),
         .tick      (tick),
         .time_left (bay_time[i]),
         .running   (running[i]),
         .expired   (expired[i])
      );
   end

   // Selected bay's time; out-of-range selects show zero
   always_comb begin
      sel_time = '0;
      for (int i = 0; i < N_BAYS; i++) begin
         if (bay_sel == SEL_W'(i)) sel_time = bay_time[i];
      end
   end

   // Registered BCD split of the selected time
   always_ff @(posedge clk) begin
      if (!reset) begin
         time_tens <= 4'd0;
         time_ones <= 4'd0;
      end else begin
         time_tens <= 4'(sel_time / TIME_W'(10));
         time_ones <= 4'(sel_time % TIME_W'(10));
      end
   end

endmodule
